bit_reverse_ctrl: RTL and testbench
===================================

// Module: bit_reverse_ctrl
// PURPOSE
//  Ping-pong bit-reversal reorder controller between the R22SDF pipeline output and the
//  stream consumer. Writes each N-point frame into one half of an external true-dual-port
//  BRAM (port0) at bit-reversed addresses, and reads the other half out in natural order
//  (port1). The output stream has valid/ready flow control, and a 2-entry skid FIFO absorbs
//  the 1-cycle BRAM read latency.
// PARAMETERS
//  DWIDTH  32  sample width (packed {re,im}); matches the DPBRAM DWIDTH
//  LOG2N   11  log2 of FFT length N
//  AWIDTH  12  BRAM address width; must equal LOG2N+1 (MSB = bank select)
// PORTS
//  clk        in   1       clock; all logic on posedge
//  rst        in   1       synchronous, active-high reset
//  in_valid   in   1       input sample valid
//  in_ready   out  1       controller can accept a sample
//  in_data    in   DWIDTH  FFT output sample, bit-reversed order
//  out_valid  out  1       output sample valid
//  out_ready  in   1       consumer accepts the sample
//  out_data   out  DWIDTH  sample in natural order
//  addr0      out  AWIDTH  BRAM port0 address: {wr_bank, bitrev(wr_cnt)}
//  ce0,we0    out  1,1     BRAM port0 enables; both =1 on an accepted input, else 0
//  d0         out  DWIDTH  BRAM port0 write data (=in_data, combinational)
//  addr1      out  AWIDTH  BRAM port1 address: {rd_bank, rd_cnt}
//  ce1        out  1       BRAM port1 read enable (we1 tied 0 at instantiation)
//  q1         in   DWIDTH  BRAM port1 read data, valid the cycle after ce1
// BEHAVIOUR
//  - Reset: wr_bank=rd_bank=0, wr_cnt=rd_cnt=0, bank_full=2'b00, skid FIFO empty,
//    read-in-flight flag 0. Outputs: out_valid=0, out_data=0, ce0=we0=ce1=0, in_ready=1.
//  - Reset mid-frame discards all partial and full frames. BRAM contents are don't-care.
//  - Write side: in_ready = !bank_full[wr_bank]. Accept = in_valid & in_ready. On accept,
//    port0 writes the sample to {wr_bank, bitrev(wr_cnt)} and wr_cnt increments.
//  - Frame end on the write side: an accept with wr_cnt==N-1 sets bank_full[wr_bank],
//    toggles wr_bank, and wraps wr_cnt to 0.
//  - Read side: issue a read (ce1=1) when bank_full[rd_bank] & (fifo_cnt + inflight - pop) < 2,
//    where pop = out_valid & out_ready. On issue, rd_cnt increments.
//  - Frame end on the read side: an issue with rd_cnt==N-1 clears bank_full[rd_bank], toggles
//    rd_bank, and wraps rd_cnt. The bank is freed the cycle after its last read is issued.
//  - inflight is registered ce1. When inflight=1, q1 is pushed into the skid FIFO.
//    out_valid = fifo_cnt != 0; out_data = FIFO head (registered).
//  - Latency: if the last sample of a frame is accepted at cycle T, ce1 rises at T+1 and the
//    first out_valid is at T+2.
//  - Throughput: 1 sample/clk with out_ready=1. Continuous input never stalls while the
//    consumer keeps up.
//  - Both banks full: in_ready=0 until the reader frees a bank. The writer and reader never
//    touch the same bank at once, so set/clear of bank_full always hit different bits.
//  - out_ready low: reads stop once fifo_cnt+inflight reaches 2. No sample is dropped or
//    duplicated. out_data holds stable while out_valid & !out_ready.
//  - Counters are LOG2N bits wide and wrap naturally. bitrev is a pure wire reversal.
// CONFIGURATION
//  BR_FRAME_FLAGS_EN defined: adds output ports out_sof and out_eof (1 bit each). These flags
//    travel through the skid FIFO with the data: out_sof=1 on natural index 0, out_eof=1 on
//    index N-1. Both are 0 in reset.
//  BR_FRAME_FLAGS_EN undefined: neither port exists, the FIFO stores DWIDTH bits only, and
//    behaviour is otherwise identical.
// TESTING  (LOG2N=3, N=8, AWIDTH=4, BRAM model with MEM_SIZE=16)
//  1. Stream in_data=0..7 with out_ready=1 -> out_data 0,4,2,6,1,5,3,7. First out_valid 2 clk
//     after the 8th accept.
//  2. 4 back-to-back frames (values 0..31) with out_ready=1 -> in_ready stays 1 throughout;
//     each frame's outputs are bit-reverse permuted; 32 outputs, no gaps after the first.
//  3. out_ready=0 held for 20 clk while 3 frames are offered -> in_ready drops after 16
//     accepts (both banks full), fifo_cnt=2. Releasing out_ready drains all 16 in order.
//  4. out_ready toggling 1010... during a frame -> out_data is stable across stalls, and the
//     sequence 0,4,2,6,1,5,3,7 comes out exactly once.
//  5. Assert rst after 5 accepts of frame 1 -> next clk: out_valid=0, in_ready=1, ce0=ce1=0. A
//     fresh frame 100..107 then yields 100,104,102,106,101,105,103,107.
//  6. With BR_FRAME_FLAGS_EN, case 1 -> out_sof=1 only with data 0, out_eof=1 only with data 7.

Source files
------------

// File: rtl/bit_reverse_ctrl.sv
// Ping-pong bit-reversal reorder controller: writes frames bit-reversed into one BRAM bank, reads the other out in order.
// Optional define BR_FRAME_FLAGS_EN adds out_sof/out_eof frame markers carried through the skid FIFO.
module bit_reverse_ctrl #(
    parameter int DWIDTH = 32,
    parameter int LOG2N  = 11,
    parameter int AWIDTH = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DWIDTH-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DWIDTH-1:0] out_data,
`ifdef BR_FRAME_FLAGS_EN
    output logic              out_sof,
    output logic              out_eof,
`endif
    output logic [AWIDTH-1:0] addr0,
    output logic              ce0,
    output logic              we0,
    output logic [DWIDTH-1:0] d0,
    output logic [AWIDTH-1:0] addr1,
    output logic              ce1,
    input  logic [DWIDTH-1:0] q1
);

`ifdef BR_FRAME_FLAGS_EN
    localparam int FW = DWIDTH + 2;
`else
    localparam int FW = DWIDTH;
`endif
    localparam logic [LOG2N-1:0] CNT_LAST = {LOG2N{1'b1}};

    logic             wr_bank;
    logic             rd_bank;
    logic [LOG2N-1:0] wr_cnt;
    logic [LOG2N-1:0] rd_cnt;
    logic [LOG2N-1:0] wr_rev;
    logic [1:0]       bank_full;
    logic [1:0]       bank_full_nxt;
    logic             inflight;
    logic             accept;
    logic             issue;
    logic             pop;
    logic [2:0]       occupancy;

    logic [FW-1:0]    fifo_mem [2];
    logic [FW-1:0]    push_word;
    logic [FW-1:0]    fifo_head;
    logic             fifo_wp;
    logic             fifo_rp;
    logic [1:0]       fifo_cnt;

    always_comb begin
        wr_rev = '0;
        for (int i = 0; i < LOG2N; i++) begin
            wr_rev[i] = wr_cnt[LOG2N-1-i];
        end
    end

    assign in_ready = !bank_full[wr_bank];
    assign accept   = in_valid && in_ready;
    assign ce0      = accept;
    assign we0      = accept;
    assign d0       = in_data;
    assign addr0    = {wr_bank, wr_rev};

    // Words already buffered or on their way from the BRAM, minus the one leaving this cycle.
    assign pop       = out_valid && out_ready;
    assign occupancy = {1'b0, fifo_cnt} + {2'b00, inflight} - {2'b00, pop};
    assign issue     = bank_full[rd_bank] && (occupancy < 3'd2);
    assign ce1       = issue;
    assign addr1     = {rd_bank, rd_cnt};

    always_comb begin
        bank_full_nxt = bank_full;
        if (accept && (wr_cnt == CNT_LAST)) begin
            bank_full_nxt[wr_bank] = 1'b1;
        end
        if (issue && (rd_cnt == CNT_LAST)) begin
            bank_full_nxt[rd_bank] = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_bank   <= 1'b0;
            rd_bank   <= 1'b0;
            wr_cnt    <= '0;
            rd_cnt    <= '0;
            bank_full <= 2'b00;
            inflight  <= 1'b0;
        end else begin
            bank_full <= bank_full_nxt;
            inflight  <= issue;
            if (accept) begin
                wr_cnt <= wr_cnt + 1'b1;
                if (wr_cnt == CNT_LAST) begin
                    wr_bank <= !wr_bank;
                end
            end
            if (issue) begin
                rd_cnt <= rd_cnt + 1'b1;
                if (rd_cnt == CNT_LAST) begin
                    rd_bank <= !rd_bank;
                end
            end
        end
    end

`ifdef BR_FRAME_FLAGS_EN
    logic inflight_sof;
    logic inflight_eof;

    // Frame markers follow the read that produced them, one cycle behind ce1 like q1.
    always_ff @(posedge clk) begin
        if (rst) begin
            inflight_sof <= 1'b0;
            inflight_eof <= 1'b0;
        end else begin
            inflight_sof <= issue && (rd_cnt == '0);
            inflight_eof <= issue && (rd_cnt == CNT_LAST);
        end
    end

    assign push_word = {inflight_sof, inflight_eof, q1};
    assign out_sof   = fifo_head[DWIDTH+1];
    assign out_eof   = fifo_head[DWIDTH];
`else
    assign push_word = q1;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            fifo_mem[0] <= '0;
            fifo_mem[1] <= '0;
            fifo_wp     <= 1'b0;
            fifo_rp     <= 1'b0;
            fifo_cnt    <= 2'd0;
        end else begin
            if (inflight) begin
                fifo_mem[fifo_wp] <= push_word;
                fifo_wp           <= !fifo_wp;
            end
            if (pop) begin
                fifo_rp <= !fifo_rp;
            end
            fifo_cnt <= fifo_cnt + {1'b0, inflight} - {1'b0, pop};
        end
    end

    // A push never lands on the head slot while it is valid, so the head holds during stalls.
    assign fifo_head = fifo_mem[fifo_rp];
    assign out_valid = (fifo_cnt != 2'd0);
    assign out_data  = fifo_head[DWIDTH-1:0];

endmodule

// File: tb/tb_bit_reverse_ctrl.sv
// Directed bench for bit_reverse_ctrl with N=8 and a behavioural 16-word dual-port BRAM.
// Covers BR_FRAME_FLAGS_EN frame markers when that define is set for the build.
module tb_bit_reverse_ctrl;
    localparam int DWIDTH = 32;
    localparam int LOG2N  = 3;
    localparam int AWIDTH = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [DWIDTH-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [DWIDTH-1:0] out_data;
`ifdef BR_FRAME_FLAGS_EN
    logic              out_sof;
    logic              out_eof;
`endif
    logic [AWIDTH-1:0] addr0;
    logic              ce0;
    logic              we0;
    logic [DWIDTH-1:0] d0;
    logic [AWIDTH-1:0] addr1;
    logic              ce1;
    logic [DWIDTH-1:0] q1;

    bit_reverse_ctrl #(.DWIDTH(DWIDTH), .LOG2N(LOG2N), .AWIDTH(AWIDTH)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
`ifdef BR_FRAME_FLAGS_EN
        .out_sof(out_sof), .out_eof(out_eof),
`endif
        .addr0(addr0), .ce0(ce0), .we0(we0), .d0(d0),
        .addr1(addr1), .ce1(ce1), .q1(q1)
    );

    always #5 clk = ~clk;

    logic [DWIDTH-1:0] mem [16];
    always @(posedge clk) begin
        if (ce0 && we0) mem[addr0] <= d0;
        if (ce1) q1 <= mem[addr1];
    end

    typedef struct {
        logic [31:0] din;
        logic [2:0]  addr_lo;
        logic [31:0] dout;
    } vec_t;

    typedef struct {
        logic [31:0] data;
        logic        sof;
        logic        eof;
    } exp_t;

    vec_t tab [16];
    int   rev_lut [8];
    exp_t exp_q [$];

    int checks = 0;
    int errors = 0;
    int cycle = 0;
    int accepts = 0;
    int out_count = 0;
    int first_cycle = 0;
    int last_cycle = 0;
    int stall_count = 0;
    int ready_mode = 0;
    bit hold_pending = 0;
    bit driver_done = 0;
    logic [DWIDTH-1:0] held_data;

    task automatic checkOutput(input string name, input logic [63:0] got, input logic [63:0] expv);
        checks++;
        if (got !== expv) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, got, expv);
        end
    endtask

    always @(posedge clk) cycle++;

    // out_ready pattern, driven just after each rising edge.
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            case (ready_mode)
                1:       out_ready = ~out_ready;
                2:       out_ready = 1'b0;
                default: out_ready = 1'b1;
            endcase
        end
    end

    // Output monitor / scoreboard, sampled on the falling edge.
    always @(negedge clk) begin
        if (!rst) begin
            if (hold_pending) begin
                checkOutput("stall_hold", 64'({out_valid, out_data}), 64'({1'b1, held_data}));
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_output: got %0h, expected none", out_data);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    checkOutput("out_data", 64'(out_data), 64'(e.data));
`ifdef BR_FRAME_FLAGS_EN
                    checkOutput("out_sof", 64'(out_sof), 64'(e.sof));
                    checkOutput("out_eof", 64'(out_eof), 64'(e.eof));
`endif
                end
                if (out_count == 0) first_cycle = cycle;
                last_cycle = cycle;
                out_count++;
            end
            hold_pending = out_valid && !out_ready;
            held_data = out_data;
            if (in_valid && in_ready) accepts++;
        end else begin
            hold_pending = 0;
        end
    end

    task automatic sendSample(input logic [31:0] v, input bit chk, input logic [3:0] exp_addr);
        bit acc;
        int guard;
        acc = 0;
        guard = 0;
        in_valid = 1'b1;
        in_data = v;
        while (!acc && guard < 300) begin
            @(negedge clk);
            acc = in_ready;
            if (acc && chk) begin
                checkOutput("addr0", 64'(addr0), 64'(exp_addr));
                checkOutput("ce0_we0", 64'({ce0, we0}), 64'(2'b11));
            end
            @(posedge clk);
            #1;
            guard++;
        end
        if (guard > 1) stall_count++;
        if (!acc) begin
            checks++;
            errors++;
            $display("[TB] FAIL accept_timeout: got in_ready=0, expected accept of %0h", v);
        end
    endtask

    task automatic applyStimulus(input int base_idx, input logic bank, input bit chk);
        for (int k = 0; k < 8; k++) begin
            sendSample(tab[base_idx + k].din, chk, {bank, tab[base_idx + k].addr_lo});
        end
        in_valid = 1'b0;
    endtask

    task automatic pushTableFrame(input int base_idx);
        exp_t e;
        for (int i = 0; i < 8; i++) begin
            e.data = tab[base_idx + i].dout;
            e.sof = (i == 0);
            e.eof = (i == 7);
            exp_q.push_back(e);
        end
    endtask

    task automatic pushArithFrame(input logic [31:0] base);
        exp_t e;
        for (int i = 0; i < 8; i++) begin
            e.data = base + 32'(rev_lut[i]);
            e.sof = (i == 0);
            e.eof = (i == 7);
            exp_q.push_back(e);
        end
    endtask

    task automatic sendArithFrame(input logic [31:0] base);
        for (int k = 0; k < 8; k++) begin
            sendSample(base + 32'(k), 1'b0, 4'h0);
        end
    endtask

    task automatic waitDrain(input string name);
        int guard;
        guard = 0;
        while ((exp_q.size() != 0 || out_valid) && guard < 500) begin
            @(posedge clk);
            #1;
            guard++;
        end
        checkOutput(name, 64'(exp_q.size()), 64'(0));
        exp_q.delete();
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL global_timeout: got no finish, expected finish");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        rev_lut = '{0, 4, 2, 6, 1, 5, 3, 7};
        tab[0]  = '{32'd0,   3'd0, 32'd0};
        tab[1]  = '{32'd1,   3'd4, 32'd4};
        tab[2]  = '{32'd2,   3'd2, 32'd2};
        tab[3]  = '{32'd3,   3'd6, 32'd6};
        tab[4]  = '{32'd4,   3'd1, 32'd1};
        tab[5]  = '{32'd5,   3'd5, 32'd5};
        tab[6]  = '{32'd6,   3'd3, 32'd3};
        tab[7]  = '{32'd7,   3'd7, 32'd7};
        tab[8]  = '{32'd100, 3'd0, 32'd100};
        tab[9]  = '{32'd101, 3'd4, 32'd104};
        tab[10] = '{32'd102, 3'd2, 32'd102};
        tab[11] = '{32'd103, 3'd6, 32'd106};
        tab[12] = '{32'd104, 3'd1, 32'd101};
        tab[13] = '{32'd105, 3'd5, 32'd105};
        tab[14] = '{32'd106, 3'd3, 32'd103};
        tab[15] = '{32'd107, 3'd7, 32'd107};

        rst = 1'b1;
        in_valid = 1'b0;
        in_data = '0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_in_ready", 64'(in_ready), 64'(1));
        checkOutput("rst_out_valid", 64'(out_valid), 64'(0));
        checkOutput("rst_ce", 64'({ce0, we0, ce1}), 64'(0));
        checkOutput("rst_out_data", 64'(out_data), 64'(0));
        rst = 1'b0;

        $display("[TB] single frame reorder and latency");
        pushTableFrame(0);
        applyStimulus(0, 1'b0, 1'b1);
        checkOutput("lat_ce1_t0", 64'({ce1, out_valid}), 64'(2'b10));
        @(posedge clk);
        #1;
        checkOutput("lat_valid_t1", 64'(out_valid), 64'(0));
        @(posedge clk);
        #1;
        checkOutput("lat_valid_t2", 64'(out_valid), 64'(1));
        waitDrain("frame1_drain");

        $display("[TB] four back-to-back frames");
        out_count = 0;
        stall_count = 0;
        for (int f = 0; f < 4; f++) pushArithFrame(32'(f * 8));
        for (int f = 0; f < 4; f++) sendArithFrame(32'(f * 8));
        in_valid = 1'b0;
        checkOutput("b2b_stalls", 64'(stall_count), 64'(0));
        waitDrain("b2b_drain");
        checkOutput("b2b_count", 64'(out_count), 64'(32));
        checkOutput("b2b_no_gaps", 64'(last_cycle - first_cycle), 64'(31));

        $display("[TB] consumer stalled with both banks full");
        ready_mode = 2;
        @(posedge clk);
        #3;
        accepts = 0;
        driver_done = 0;
        for (int f = 0; f < 3; f++) pushArithFrame(32'(200 + f * 8));
        fork
            begin
                for (int f = 0; f < 3; f++) sendArithFrame(32'(200 + f * 8));
                in_valid = 1'b0;
                driver_done = 1;
            end
        join_none
        repeat (20) @(posedge clk);
        #3;
        checkOutput("full_accepts", 64'(accepts), 64'(16));
        checkOutput("full_in_ready", 64'(in_ready), 64'(0));
        checkOutput("full_ce1", 64'(ce1), 64'(0));
        checkOutput("full_out_valid", 64'(out_valid), 64'(1));
        ready_mode = 0;
        begin
            int guard;
            guard = 0;
            while (!driver_done && guard < 400) begin
                @(posedge clk);
                guard++;
            end
            checkOutput("full_driver_done", 64'(driver_done), 64'(1));
        end
        #1;
        waitDrain("full_drain");

        $display("[TB] toggling out_ready");
        ready_mode = 1;
        pushTableFrame(0);
        applyStimulus(0, 1'b0, 1'b0);
        waitDrain("toggle_drain");
        ready_mode = 0;
        repeat (2) @(posedge clk);
        #1;

        $display("[TB] reset mid-frame");
        for (int k = 0; k < 5; k++) sendSample(tab[8 + k].din, 1'b0, 4'h0);
        in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("mid_rst_out_valid", 64'(out_valid), 64'(0));
        checkOutput("mid_rst_in_ready", 64'(in_ready), 64'(1));
        checkOutput("mid_rst_ce", 64'({ce0, ce1}), 64'(0));
        rst = 1'b0;
        exp_q.delete();
        pushTableFrame(8);
        applyStimulus(8, 1'b0, 1'b1);
        waitDrain("post_rst_drain");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
